// File: rtl/bit_permute_pkg.sv
// Shared types for the bit/byte permutation pipe.
// Mode encodings travel with each beat; fill_t is the output-queue occupancy.
// No logic lives here.
package bit_permute_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t PASS        = 2'b00;  // out = in
  localparam mode_t BITREV      = 2'b01;  // whole-word bit reverse
  localparam mode_t BYTE_BITREV = 2'b10;  // each byte bit-reversed in place
  localparam mode_t BYTESWAP    = 2'b11;  // byte order reversed, bits within bytes kept

  // Occupancy of the 2-entry output queue.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_t;

endpackage

// File: rtl/bit_permute_pipe_if.sv
// Stream bundle for bit_permute_pipe: input beat (data + mode) and output result.
// slave = the permutation unit, master = the producer/consumer side driving it.
// Ports: in_valid/in_ready/in_data/in_mode, out_valid/out_ready/out_data.
interface bit_permute_pipe_if
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  mode_t            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/bit_permute_pipe_permute.sv
// Combinational bit/byte permutation of one WIDTH-bit word selected by mode.
// Latency: 0 cycles (pure logic).
// Backpressure: none; ports: data/mode in, permuted out.
module bit_permute
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  output logic [WIDTH-1:0] permuted
);

  localparam int NBYTES = WIDTH / 8;

  always_comb begin
    permuted = data;
    case (mode)
      PASS: begin
        permuted = data;
      end
      BITREV: begin
        for (int i = 0; i < WIDTH; i++) begin
          permuted[i] = data[WIDTH-1-i];
        end
      end
      BYTE_BITREV: begin
        for (int b = 0; b < NBYTES; b++) begin
          for (int j = 0; j < 8; j++) begin
            permuted[8*b+j] = data[8*b+7-j];
          end
        end
      end
      BYTESWAP: begin
        for (int b = 0; b < NBYTES; b++) begin
          permuted[8*b +: 8] = data[8*(NBYTES-1-b) +: 8];
        end
      end
    endcase
  end

endmodule

// File: rtl/bit_permute_pipe.sv
// Handshaked bit/byte permutation with a 2-entry output queue and accepted-beat counter.
// Latency: 1 cycle from input transfer to out_valid when the queue is empty; 1 beat/cycle sustained.
// Backpressure: in_ready = queue not full, registered only (no combinational path from out_ready).
// Ports: clk, rst_n (async, active-low), bus (slave stream), beat_cnt (wrapping), busy (queue non-empty).
module bit_permute_pipe
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_permute_pipe_if.slave bus,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              busy
);

  if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
    $error("bit_permute_pipe: WIDTH must be a multiple of 8 and at least 8");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("bit_permute_pipe: CNT_W must be at least 1");
  end

  logic [WIDTH-1:0] permuted;
  logic [WIDTH-1:0] mem_q [0:1];
  logic [WIDTH-1:0] mem_d [0:1];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  fill_t            fill_q, fill_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             push;
  logic             pop;

  // Permutation happens before the queue so the mode never needs storing.
  bit_permute #(.WIDTH(WIDTH)) u_permute (
    .data     (bus.in_data),
    .mode     (bus.in_mode),
    .permuted (permuted)
  );

  assign bus.in_ready  = (fill_q != FULL);
  assign bus.out_valid = (fill_q != EMPTY);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign busy          = (fill_q != EMPTY);
  assign beat_cnt      = beat_cnt_q;

  assign push = bus.in_valid && (fill_q != FULL);
  assign pop  = bus.out_ready && (fill_q != EMPTY);

  always_comb begin
    fill_d     = fill_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = permuted;
      wr_ptr_d        = ~wr_ptr_q;
      beat_cnt_d      = beat_cnt_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous push and pop leaves occupancy unchanged; the pointers keep order.
    case ({push, pop})
      2'b10:   fill_d = (fill_q == EMPTY) ? ONE : FULL;
      2'b01:   fill_d = (fill_q == FULL) ? ONE : EMPTY;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= EMPTY;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      fill_q     <= fill_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Self-checking bench for bit_permute_pipe: an 8-bit instance driven from a vector
// table, and a 16-bit instance with a 4-bit beat counter driven by directed
// sequences and random traffic against a queue-based reference model.
module tb_bit_permute_pipe;
  import bit_permute_pkg::*;

  logic clk;
  logic rst_n;

  bit_permute_pipe_if #(.WIDTH(8))  bus8 ();
  bit_permute_pipe_if #(.WIDTH(16)) bus16 ();

  logic [15:0] beat_cnt8;
  logic        busy8;
  logic [3:0]  beat_cnt16;
  logic        busy16;

  bit_permute_pipe #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus8),
    .beat_cnt (beat_cnt8),
    .busy     (busy8)
  );

  bit_permute_pipe #(.WIDTH(16), .CNT_W(4)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus16),
    .beat_cnt (beat_cnt16),
    .busy     (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference permutation built from streaming operators.
  function automatic logic [15:0] model16(input logic [15:0] x, input mode_t m);
    logic [15:0] sw;
    logic [15:0] y;
    sw = {<<8{x}};
    case (m)
      BITREV:      y = {<<{x}};
      BYTE_BITREV: y = {<<{sw}};
      BYTESWAP:    y = sw;
      default:     y = x;
    endcase
    return y;
  endfunction

  // Reference queue and counter for the 16-bit instance.
  logic [15:0] exp_q[$];
  logic [3:0]  exp_cnt;

  // One cycle on the 16-bit instance: drive at negedge, compare just after,
  // then update the model with the transfers that the next posedge performs.
  task automatic step16(input logic vld, input logic [15:0] d, input mode_t m,
                        input logic ordy, output logic acc, output logic popped,
                        output logic [15:0] pdat);
    int sz;
    @(negedge clk);
    bus16.in_valid  = vld;
    bus16.in_data   = d;
    bus16.in_mode   = m;
    bus16.out_ready = ordy;
    #1;
    sz = exp_q.size();
    check("out_valid", 64'(bus16.out_valid), 64'(sz != 0));
    check("in_ready", 64'(bus16.in_ready), 64'(sz != 2));
    check("busy", 64'(busy16), 64'(sz != 0));
    check("beat_cnt", 64'(beat_cnt16), 64'(exp_cnt));
    acc    = vld && bus16.in_ready;
    popped = bus16.out_valid && ordy;
    pdat   = bus16.out_data;
    if (sz != 0 && ordy) begin
      check("out_data", 64'(bus16.out_data), 64'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (vld && sz != 2) begin
      exp_q.push_back(model16(d, m));
      exp_cnt = exp_cnt + 4'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  typedef struct {
    logic [7:0] din;
    mode_t      mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic        acc;
    logic        popped;
    logic [15:0] pdat;
    logic        rv;
    logic        pending;
    logic [15:0] rd;
    mode_t       rm;
    logic        ordy;

    vecs[0] = '{8'h01, BITREV,      8'h80};
    vecs[1] = '{8'h01, BYTE_BITREV, 8'h80};
    vecs[2] = '{8'hA5, BYTESWAP,    8'hA5};
    vecs[3] = '{8'h3C, PASS,        8'h3C};
    vecs[4] = '{8'hC1, BITREV,      8'h83};
    vecs[5] = '{8'h0F, BITREV,      8'hF0};
    vecs[6] = '{8'h12, BYTE_BITREV, 8'h48};
    vecs[7] = '{8'h6E, BYTESWAP,    8'h6E};

    rst_n           = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.in_data    = '0;
    bus8.in_mode    = PASS;
    bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_data   = '0;
    bus16.in_mode   = PASS;
    bus16.out_ready = 1'b0;
    exp_cnt         = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("rst_busy", 64'(busy16), 64'd0);
    check("rst_in_ready", 64'(bus16.in_ready), 64'd1);
    check("rst_out_data", 64'(bus16.out_data), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt16), 64'd0);
    check("rst8_beat_cnt", 64'(beat_cnt8), 64'd0);

    // 8-bit instance: one beat per vector, result visible the next cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.in_data  = vecs[i].din;
      bus8.in_mode  = vecs[i].mode;
      #1;
      check("w8_in_ready", 64'(bus8.in_ready), 64'd1);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      #1;
      check("w8_out_valid", 64'(bus8.out_valid), 64'd1);
      check("w8_out_data", 64'(bus8.out_data), 64'(vecs[i].exp));
      check("w8_beat_cnt", 64'(beat_cnt8), 64'(i + 1));
      @(negedge clk);
      #1;
      check("w8_drained", 64'(bus8.out_valid), 64'd0);
    end

    // All four modes back-to-back, drained one per cycle.
    step16(1'b1, 16'h1234, PASS, 1'b1, acc, popped, pdat);
    check("b2b_acc0", 64'(acc), 64'd1);
    step16(1'b1, 16'h1234, BITREV, 1'b1, acc, popped, pdat);
    check("b2b_pop0", 64'(popped), 64'd1);
    check("b2b_pass", 64'(pdat), 64'h1234);
    step16(1'b1, 16'h1234, BYTE_BITREV, 1'b1, acc, popped, pdat);
    check("b2b_bitrev", 64'(pdat), 64'h2C48);
    step16(1'b1, 16'h1234, BYTESWAP, 1'b1, acc, popped, pdat);
    check("b2b_bytebitrev", 64'(pdat), 64'h482C);
    step16(1'b0, 16'h0000, PASS, 1'b1, acc, popped, pdat);
    check("b2b_pop3", 64'(popped), 64'd1);
    check("b2b_byteswap", 64'(pdat), 64'h3412);

    // Fill the queue with the consumer stalled; third beat must be held.
    step16(1'b1, 16'hA001, PASS, 1'b0, acc, popped, pdat);
    check("full_acc_a", 64'(acc), 64'd1);
    step16(1'b1, 16'hB002, BITREV, 1'b0, acc, popped, pdat);
    check("full_acc_b", 64'(acc), 64'd1);
    step16(1'b1, 16'hC003, BYTESWAP, 1'b0, acc, popped, pdat);
    check("full_hold1", 64'(acc), 64'd0);
    step16(1'b1, 16'hC003, BYTESWAP, 1'b0, acc, popped, pdat);
    check("full_hold2", 64'(acc), 64'd0);
    step16(1'b1, 16'hC003, BYTESWAP, 1'b1, acc, popped, pdat);
    check("full_hold3", 64'(acc), 64'd0);
    check("full_out_a", 64'(pdat), 64'hA001);
    step16(1'b1, 16'hC003, BYTESWAP, 1'b1, acc, popped, pdat);
    check("full_acc_c", 64'(acc), 64'd1);
    check("full_out_b", 64'(pdat), 64'h400D);
    step16(1'b0, 16'h0000, PASS, 1'b1, acc, popped, pdat);
    check("full_out_c", 64'(pdat), 64'h03C0);
    step16(1'b0, 16'h0000, PASS, 1'b1, acc, popped, pdat);
    check("full_empty", 64'(popped), 64'd0);

    // Occupancy held at one with push and pop every cycle, then counter wrap.
    do_reset();
    step16(1'b1, 16'h0100, PASS, 1'b0, acc, popped, pdat);
    for (int i = 1; i < 10; i++) begin
      step16(1'b1, 16'h0100 + 16'(i), mode_t'(i % 4), 1'b1, acc, popped, pdat);
      check("one_acc", 64'(acc && popped), 64'd1);
    end
    step16(1'b0, 16'h0000, PASS, 1'b1, acc, popped, pdat);
    check("one_beat_cnt10", 64'(beat_cnt16), 64'd10);
    for (int i = 0; i < 7; i++) begin
      step16(1'b1, 16'h0200 + 16'(i), BITREV, 1'b1, acc, popped, pdat);
    end
    step16(1'b0, 16'h0000, PASS, 1'b1, acc, popped, pdat);
    check("wrap_beat_cnt", 64'(beat_cnt16), 64'd1);

    // Reset in the middle of a cycle with two beats queued.
    step16(1'b1, 16'hDEAD, PASS, 1'b0, acc, popped, pdat);
    step16(1'b1, 16'hBEEF, BYTESWAP, 1'b0, acc, popped, pdat);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("midrst_beat_cnt", 64'(beat_cnt16), 64'd0);
    check("midrst_in_ready", 64'(bus16.in_ready), 64'd1);
    check("midrst_out_data", 64'(bus16.out_data), 64'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step16(1'b0, 16'h0000, PASS, 1'b1, acc, popped, pdat);
      check("postrst_no_out", 64'(popped), 64'd0);
    end

    // Random traffic; a refused beat is held until it is taken.
    pending = 1'b0;
    rv      = 1'b0;
    rd      = '0;
    rm      = PASS;
    for (int c = 0; c < 600; c++) begin
      if (!pending) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = 16'($urandom);
        rm = mode_t'($urandom_range(0, 3));
      end
      if (c < 200) ordy = ($urandom_range(0, 3) != 0);
      else if (c < 400) ordy = ($urandom_range(0, 3) == 0);
      else ordy = 1'b1;
      step16(rv, rd, rm, ordy, acc, popped, pdat);
      pending = rv && !acc;
    end
    for (int i = 0; i < 3; i++) begin
      step16(1'b0, 16'h0000, PASS, 1'b1, acc, popped, pdat);
    end
    check("final_empty", 64'(bus16.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_permute_pipe.md
# bit_permute_pipe

Parametrised, handshaked bit/byte permutation unit: the sequential successor of the fixed 8-bit bit-reverse. It accepts a WIDTH-bit word with a per-beat mode, applies pass, full bit-reverse, per-byte bit-reverse or byte-order reverse, and buffers the result in a 2-entry output queue. It sits between the i4001 ROM/I/O datapath and consumers that expect the opposite bit or byte order.

## Interface
- WIDTH, 8: data width in bits; multiple of 8, ≥ 8. Any other value is an elaboration error.
- CNT_W, 16: width of the accepted-beat counter.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  input beat offered
- in_ready  output  1  unit can accept a beat
- in_data  input  WIDTH  input word
- in_mode  input  2  permutation for this beat, sampled with in_data
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  permuted word
- beat_cnt  output  CNT_W  number of accepted input beats, wrapping
- busy  output  1  queue non-empty

## Operation
- Modes (package constants):
  - 00 PASS: out = in.
  - 01 BITREV: out[i] = in[WIDTH-1-i].
  - 10 BYTE_BITREV: each byte bit-reversed in place.
  - 11 BYTESWAP: byte k moves to byte (WIDTH/8-1-k), bit order within bytes kept.
  - At WIDTH=8: BITREV == BYTE_BITREV and BYTESWAP == PASS.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- The permutation is computed combinationally from in_data/in_mode and written into a 2-entry FIFO on an input transfer. Mode is stored per beat, never as global state.
- FIFO state is count ∈ {0,1,2} (EMPTY, ONE, FULL):
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop together: count unchanged, order preserved.
  - Neither: hold.
- in_ready = (count != 2). The ready signal has no combinational path from out_ready.
- out_valid = (count != 0). busy = out_valid.
- out_data = head entry. It is stable while out_valid && !out_ready.
- beat_cnt increments by 1 on every input transfer and wraps from 2^CNT_W−1 to 0.
- in_valid with in_ready low: beat not taken, no state change. The producer must hold the beat.

## Timing
- Reset (async assert, sync-safe release): count=0, out_valid=0, busy=0, in_ready=1, out_data=0, beat_cnt=0. FIFO storage is cleared.
- Latency: input transfer in cycle N gives out_valid in cycle N+1 when the queue was empty.
- Throughput: 1 beat/cycle sustained while out_ready is held high.
- Full queue: in_ready drops the cycle after the second push without a pop. It rises the cycle after the first pop.
- Reset asserted mid-stream drops all queued beats immediately. No partial output appears after release.
- out_ready while out_valid=0 is ignored.

## Structure
- Package bit_permute_pkg holds:
  - mode localparams PASS, BITREV, BYTE_BITREV, BYTESWAP;
  - the mode_t 2-bit typedef.
- Sub-module bit_permute: purely combinational, parameter WIDTH, inputs data and mode, output permuted data. It is instantiated once on the input side.
- The top level holds the 2-entry FIFO (two data registers, read/write pointers, count) and the beat counter.

## Test plan
- WIDTH=8, out_ready=1, in_data=8'h01, mode BITREV -> out_data=8'h80 one cycle later; beat_cnt=1.
- WIDTH=16, in_data=16'h1234, modes 00/01/10/11 back-to-back -> outputs in order 16'h1234, 16'h2C48, 16'h482C, 16'h3412 on consecutive cycles.
- WIDTH=16, out_ready=0, push 3 beats:
  - first two accepted, then in_ready=0 and the third is held;
  - raise out_ready -> three outputs in order, no loss or duplication.
- Queue at ONE, simultaneous push and pop every cycle for 10 beats -> count stays 1, 10 outputs in order, beat_cnt=10.
- CNT_W=4, 17 accepted beats -> beat_cnt=1 after wrap.
- Two beats queued, assert rst_n=0 mid-cycle -> out_valid=0, beat_cnt=0, in_ready=1 immediately; no stale output after release.
